// File: rtl/icache_pkg.sv
// Shared constants and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int         OFFSET_W    = 4;
    localparam int         INDEX_W_DEF = 6;
    localparam logic [1:0] SIZE_WORD   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_UNC_REQ,
        S_UNC_WAIT
    } state_t;

endpackage

// File: rtl/icache_dm_if.sv
// SRAM-like request/response bus; used both CPU->cache (cache is slave) and cache->bridge (cache is master).
interface icache_dm_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncached;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata, uncached,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata, uncached,
        output rdata, addr_ok, data_ok
    );

endinterface

// File: rtl/icache_line_ram.sv
// Valid/tag/data storage for the cache: asynchronous read port, synchronous write port.
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [INDEX_W-1:0] i_rdIndex,
    input  logic [1:0]         i_rdWord,
    output logic               o_rdValid,
    output logic [TAG_W-1:0]   o_rdTag,
    output logic [31:0]        o_rdData,
    input  logic               i_invEn,
    input  logic               i_wrEn,
    input  logic               i_fillDone,
    input  logic [INDEX_W-1:0] i_wrIndex,
    input  logic [1:0]         i_wrWord,
    input  logic [31:0]        i_wrData,
    input  logic [TAG_W-1:0]   i_fillTag
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES][4];

    // Only the valid bits are reset; tags and data are meaningless until their line is filled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (i_invEn) begin
            r_valid[i_wrIndex] <= 1'b0;
        end else if (i_fillDone) begin
            r_valid[i_wrIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_data[i_wrIndex][i_wrWord] <= i_wrData;
        end
        if (i_fillDone) begin
            r_tag[i_wrIndex] <= i_fillTag;
        end
    end

    assign o_rdValid = r_valid[i_rdIndex];
    assign o_rdTag   = r_tag[i_rdIndex];
    assign o_rdData  = r_data[i_rdIndex][i_rdWord];

endmodule

// File: rtl/icache_dm.sv
// Read-only direct-mapped instruction cache between an SRAM-like CPU port and an SRAM-like AXI bridge port.
module icache_dm
    import icache_pkg::*;
#(
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = icache_pkg::OFFSET_W
) (
    input  logic        clk,
    input  logic        resetn,
    icache_dm_if.slave  cpu,
    icache_dm_if.master mem
);

    localparam int TAG_W = 32 - INDEX_W - OFFSET_W;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic               r_unc;
    logic [1:0]         r_cnt;
    logic               r_live;

    logic               w_live;
    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic               w_rdValid;
    logic [TAG_W-1:0]   w_rdTag;
    logic [31:0]        w_rdData;
    logic               w_hit;
    logic               w_uncDone;
    logic               w_accept;
    logic               w_memReq;
    logic               w_refill;
    logic               w_fillDone;
    logic               w_inv;
    logic               w_unused;

    // r_live keeps every output quiet for the first cycle after reset is released.
    assign w_live     = resetn & r_live;
    assign w_index    = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_tag      = r_addr[31:OFFSET_W+INDEX_W];
    assign w_word     = r_addr[3:2];

    assign w_hit      = w_live & (r_state == S_LOOKUP) & w_rdValid & (w_rdTag == w_tag) & ~r_unc;
    assign w_uncDone  = w_live & (r_state == S_UNC_WAIT) & mem.data_ok;
    assign w_accept   = w_live & cpu.req & ((r_state == S_IDLE) | w_hit);
    assign w_memReq   = w_live & ((r_state == S_MISS_REQ) | (r_state == S_UNC_REQ));
    assign w_refill   = w_live & (r_state == S_MISS_WAIT) & mem.data_ok;
    assign w_fillDone = w_refill & (r_cnt == 2'd3);
    assign w_inv      = w_live & (r_state == S_LOOKUP) & ~w_hit & ~r_unc;

    assign cpu.addr_ok = w_accept;
    assign cpu.data_ok = w_hit | w_uncDone;
    assign cpu.rdata   = w_hit ? w_rdData : (w_uncDone ? mem.rdata : '0);

    assign mem.req      = w_memReq;
    assign mem.wr       = 1'b0;
    assign mem.size     = SIZE_WORD;
    assign mem.wdata    = '0;
    assign mem.uncached = 1'b0;
    assign mem.addr     = !w_memReq               ? '0 :
                          (r_state == S_UNC_REQ)  ? r_addr :
                                                    {w_tag, w_index, r_cnt, 2'b00};

    assign w_unused = ^{cpu.wr, cpu.size, cpu.wdata};

    icache_line_ram #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lineRam (
        .clk        (clk),
        .resetn     (resetn),
        .i_rdIndex  (w_index),
        .i_rdWord   (w_word),
        .o_rdValid  (w_rdValid),
        .o_rdTag    (w_rdTag),
        .o_rdData   (w_rdData),
        .i_invEn    (w_inv),
        .i_wrEn     (w_refill),
        .i_fillDone (w_fillDone),
        .i_wrIndex  (w_index),
        .i_wrWord   (r_cnt),
        .i_wrData   (mem.rdata),
        .i_fillTag  (w_tag)
    );

    // A refill fetches the whole line one word at a time, then returns to LOOKUP where it hits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_unc   <= 1'b0;
            r_cnt   <= 2'd0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= cpu.addr;
                        r_unc   <= cpu.uncached;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (w_accept) begin
                            r_addr  <= cpu.addr;
                            r_unc   <= cpu.uncached;
                            r_state <= S_LOOKUP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_unc) begin
                        r_state <= S_UNC_REQ;
                    end else begin
                        r_cnt   <= 2'd0;
                        r_state <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (mem.addr_ok) begin
                        r_state <= S_MISS_WAIT;
                    end
                end
                S_MISS_WAIT: begin
                    if (mem.data_ok) begin
                        if (r_cnt == 2'd3) begin
                            r_state <= S_LOOKUP;
                        end else begin
                            r_cnt   <= r_cnt + 2'd1;
                            r_state <= S_MISS_REQ;
                        end
                    end
                end
                S_UNC_REQ: begin
                    if (mem.addr_ok) begin
                        r_state <= S_UNC_WAIT;
                    end
                end
                S_UNC_WAIT: begin
                    if (mem.data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: directed CPU requests, a behavioural AXI-bridge memory, decoupled response monitor.
module tb_icache_dm;

    typedef struct {
        logic [31:0] data;
        bit          isHit;
        int          acceptCycle;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    icache_dm_if cpuBus();
    icache_dm_if memBus();

    icache_dm #(.INDEX_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .cpu    (cpuBus),
        .mem    (memBus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          memLat = 0;
    int          memAccepts = 0;
    exp_t        cpuQ[$];
    logic [31:0] memQ[$];
    bit          memPending = 0;
    int          memDelay = 0;
    logic [31:0] memPendAddr = '0;
    exp_t        monEntry;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_cpuOk"}, {30'b0, cpuBus.addr_ok, cpuBus.data_ok}, 32'h0);
        checkOutput({name, "_cpuRdata"}, cpuBus.rdata, 32'h0);
        checkOutput({name, "_memReq"}, {31'b0, memBus.req}, 32'h0);
        checkOutput({name, "_memAddr"}, memBus.addr, 32'h0);
        checkOutput({name, "_memWrWdata"}, memBus.wdata | {30'b0, memBus.uncached, memBus.wr}, 32'h0);
        checkOutput({name, "_memSize"}, {30'b0, memBus.size}, 32'h2);
    endtask

    // Bridge model: accepts one request at a time, answers memLat cycles later, forgets everything on reset.
    initial begin
        memBus.addr_ok = 1'b0;
        memBus.data_ok = 1'b0;
        memBus.rdata   = '0;
        forever begin
            @(negedge clk);
            memBus.addr_ok = 1'b0;
            memBus.data_ok = 1'b0;
            memBus.rdata   = '0;
            if (!resetn) begin
                memPending = 0;
            end else if (memPending) begin
                if (memDelay > 0) begin
                    memDelay--;
                end else begin
                    memBus.data_ok = 1'b1;
                    memBus.rdata   = memWord(memPendAddr);
                    memPending     = 0;
                end
            end else if (memBus.req) begin
                if (memQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL memUnexpected actual addr=%h expected no request", memBus.addr);
                end else begin
                    checkOutput("memAddr", memBus.addr, memQ.pop_front());
                end
                memBus.addr_ok = 1'b1;
                memPending     = 1;
                memPendAddr    = memBus.addr;
                memDelay       = memLat;
                memAccepts++;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the cache presents data_ok.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (resetn) begin
                if (cpuBus.data_ok) begin
                    if (cpuQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL cpuUnexpected actual rdata=%h expected no response", cpuBus.rdata);
                    end else begin
                        monEntry = cpuQ.pop_front();
                        checkOutput({monEntry.name, "_data"}, cpuBus.rdata, monEntry.data);
                        if (monEntry.isHit) begin
                            checkOutput({monEntry.name, "_latency"}, 32'(cycle - monEntry.acceptCycle), 32'd1);
                        end
                    end
                end else if (cpuBus.rdata !== 32'h0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rdataIdle actual=%h expected=00000000", cpuBus.rdata);
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic unc,
                                 input logic [31:0] expData, input bit isHit, output int acc);
        exp_t e;
        bit   got = 0;
        acc = -1;
        cpuBus.req      = 1'b1;
        cpuBus.addr     = addr;
        cpuBus.uncached = unc;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #3;
            if (cpuBus.addr_ok) got = 1;
        end
        checks++;
        if (got) begin
            e.data        = expData;
            e.isHit       = isHit;
            e.acceptCycle = cycle;
            e.name        = name;
            acc           = cycle;
            cpuQ.push_back(e);
        end else begin
            errors++;
            $display("[TB] FAIL %s_accept actual=no addr_ok expected=addr_ok within 200 cycles", name);
        end
        @(posedge clk);
        #1;
        cpuBus.req = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && (cpuQ.size() != 0 || memQ.size() != 0); i++) begin
            @(negedge clk);
            #3;
        end
        checkOutput({name, "_drain"}, 32'(cpuQ.size() + memQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pushLine(input logic [31:0] base);
        for (int w = 0; w < 4; w++) memQ.push_back(base + 32'(w * 4));
    endtask

    initial begin
        int acc0;
        int acc1;
        int acc2;
        int base;
        bit got;

        cpuBus.req      = 1'b1;
        cpuBus.wr       = 1'b0;
        cpuBus.size     = 2'b10;
        cpuBus.addr     = 32'h1FC0_0000;
        cpuBus.wdata    = 32'h0;
        cpuBus.uncached = 1'b0;
        resetn          = 1'b0;

        repeat (3) begin
            @(negedge clk);
            #3;
            checkResetOutputs("inReset");
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        #3;
        checkResetOutputs("firstCycle");
        @(posedge clk);
        #1;
        cpuBus.req = 1'b0;

        $display("[TB] cold miss");
        memLat = 0;
        base = memAccepts;
        pushLine(32'h1FC0_0000);
        cpuBus.wr    = 1'b1;
        cpuBus.wdata = 32'hDEAD_BEEF;
        applyStimulus("coldMiss", 32'h1FC0_0004, 1'b0, 32'h459A_5A5E, 1'b0, acc0);
        cpuBus.wr    = 1'b0;
        waitDrain("coldMiss");
        checkOutput("coldMiss_reads", 32'(memAccepts - base), 32'd4);

        $display("[TB] back-to-back hits");
        base = memAccepts;
        applyStimulus("hit0", 32'h1FC0_0000, 1'b0, 32'h459A_5A5A, 1'b1, acc0);
        applyStimulus("hit1", 32'h1FC0_0004, 1'b0, 32'h459A_5A5E, 1'b1, acc1);
        applyStimulus("hit2", 32'h1FC0_0008, 1'b0, 32'h459A_5A52, 1'b1, acc2);
        waitDrain("hits");
        checkOutput("hits_spacing01", 32'(acc1 - acc0), 32'd1);
        checkOutput("hits_spacing12", 32'(acc2 - acc1), 32'd1);
        checkOutput("hits_reads", 32'(memAccepts - base), 32'd0);

        $display("[TB] conflict");
        memLat = 1;
        pushLine(32'h0000_0010);
        applyStimulus("conf0", 32'h0000_0010, 1'b0, 32'h5A5A_5A4A, 1'b0, acc0);
        waitDrain("conf0");
        applyStimulus("conf0Hit", 32'h0000_001C, 1'b0, 32'h5A5A_5A46, 1'b1, acc0);
        waitDrain("conf0Hit");
        pushLine(32'h0000_0410);
        applyStimulus("conf1", 32'h0000_0410, 1'b0, 32'h5A5A_5E4A, 1'b0, acc0);
        waitDrain("conf1");
        pushLine(32'h0000_0010);
        applyStimulus("conf0Again", 32'h0000_0010, 1'b0, 32'h5A5A_5A4A, 1'b0, acc0);
        waitDrain("conf0Again");

        $display("[TB] uncached");
        memLat = 0;
        base = memAccepts;
        memQ.push_back(32'hBFC0_0000);
        applyStimulus("unc0", 32'hBFC0_0000, 1'b1, 32'hE59A_5A5A, 1'b0, acc0);
        waitDrain("unc0");
        memQ.push_back(32'hBFC0_0000);
        applyStimulus("unc1", 32'hBFC0_0000, 1'b1, 32'hE59A_5A5A, 1'b0, acc0);
        waitDrain("unc1");
        memQ.push_back(32'hBFC0_0014);
        applyStimulus("unc2", 32'hBFC0_0014, 1'b1, 32'hE59A_5A4E, 1'b0, acc0);
        waitDrain("unc2");
        checkOutput("unc_reads", 32'(memAccepts - base), 32'd3);
        applyStimulus("afterUncHit", 32'h1FC0_0004, 1'b0, 32'h459A_5A5E, 1'b1, acc0);
        waitDrain("afterUncHit");

        $display("[TB] reset mid-refill");
        base = memAccepts;
        memQ.push_back(32'h2000_0020);
        memQ.push_back(32'h2000_0024);
        memQ.push_back(32'h2000_0028);
        cpuBus.req      = 1'b1;
        cpuBus.addr     = 32'h2000_0020;
        cpuBus.uncached = 1'b0;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            #3;
            if (cpuBus.addr_ok) got = 1;
        end
        checkOutput("rstMiss_accept", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        cpuBus.req = 1'b0;
        for (int i = 0; i < 200 && memAccepts != base + 3; i++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("rstMiss_thirdReq", 32'(memAccepts - base), 32'd3);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        #3;
        checkResetOutputs("midRefillReset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        #3;
        checkResetOutputs("afterMidReset");
        @(posedge clk);
        #1;
        pushLine(32'h2000_0020);
        applyStimulus("rstRefill", 32'h2000_0020, 1'b0, 32'h7A5A_5A7A, 1'b0, acc0);
        waitDrain("rstRefill");
        applyStimulus("rstRefillHit", 32'h2000_0028, 1'b0, 32'h7A5A_5A72, 1'b1, acc0);
        waitDrain("rstRefillHit");

        checkOutput("finalQueues", 32'(cpuQ.size() + memQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=still running expected=finished by 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, set-index width (64 lines).
REQ-002 SHALL have parameter OFFSET_W, fixed 4, byte-offset width (4-word, 16-byte line); tag width = 32-INDEX_W-OFFSET_W.
REQ-003 SHALL have port clk  in  1  single clock; one clock, all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have CPU-side sram-like ports: cpu_inst_req in 1, cpu_inst_wr in 1, cpu_inst_size in 2, cpu_inst_addr in 32 (physical), cpu_inst_wdata in 32, cpu_inst_uncached in 1, cpu_inst_rdata out 32, cpu_inst_addr_ok out 1, cpu_inst_data_ok out 1.
REQ-006 SHALL have memory-side sram-like ports to the AXI bridge: cache_inst_req out 1, cache_inst_wr out 1, cache_inst_size out 2, cache_inst_addr out 32, cache_inst_wdata out 32, cache_inst_rdata in 32, cache_inst_addr_ok in 1, cache_inst_data_ok in 1.

Function
REQ-007 SHALL be read-only: cpu_inst_wr, cpu_inst_size, cpu_inst_wdata ignored; cache_inst_wr=0, cache_inst_size=2'b10, cache_inst_wdata=0 always.
REQ-008 SHALL be direct-mapped: per line one valid bit, one tag, four 32-bit words; index=addr[OFFSET_W+INDEX_W-1:OFFSET_W], word=addr[3:2].
REQ-009 SHALL implement states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UNC_REQ, UNC_WAIT.
REQ-010 SHALL assert cpu_inst_addr_ok combinationally when cpu_inst_req=1 and (state=IDLE or (state=LOOKUP and hit)); acceptance latches addr and uncached and moves to LOOKUP.
REQ-011 SHALL in LOOKUP evaluate hit = valid & tag match & ~uncached_q; on hit assert cpu_inst_data_ok with cpu_inst_rdata = selected word that cycle, next state LOOKUP if a new request is accepted same cycle, else IDLE.
REQ-012 SHALL give hit latency of exactly one cycle after addr_ok and sustain one hit per cycle back-to-back.
REQ-013 SHALL never assert data_ok in the same cycle as addr_ok for the same request.
REQ-014 SHALL in LOOKUP with miss and cached go to MISS_REQ, refill counter cnt=0; uncached go to UNC_REQ; no addr_ok in either case.
REQ-015 SHALL in MISS_REQ drive cache_inst_req=1, cache_inst_addr={tag_q,index_q,cnt,2'b00}; on cache_inst_addr_ok go MISS_WAIT.
REQ-016 SHALL keep at most one memory transaction outstanding; cache_inst_req=0 outside MISS_REQ/UNC_REQ.
REQ-017 SHALL in MISS_WAIT on cache_inst_data_ok write cache_inst_rdata into word cnt; cnt<3: cnt+1, MISS_REQ; cnt=3: write tag, set valid, go LOOKUP (which then hits).
REQ-018 SHALL clear the victim line's valid bit on entering MISS_REQ so a partial line is never hit.
REQ-019 SHALL in UNC_REQ issue one read at the exact request address; in UNC_WAIT on cache_inst_data_ok assert cpu_inst_data_ok, pass cache_inst_rdata through, go IDLE; no allocation.
REQ-020 SHALL hold cpu_inst_rdata=0 when cpu_inst_data_ok=0.
REQ-021 SHALL replace lines unconditionally on conflict (same index, different tag).

Reset
REQ-022 SHALL on resetn=0 at a clock edge: state IDLE, all valid bits 0, cnt 0, latched addr 0; tag/data arrays need no reset.
REQ-023 SHALL drive all outputs 0 during reset and the first cycle after, except cache_inst_size=2'b10.
REQ-024 SHALL abandon any refill or uncached access on reset; the AXI bridge resets on the same resetn.

Structure
REQ-025 SHALL put state encoding, OFFSET_W, default INDEX_W, and SIZE_WORD=2'b10 in shared package icache_pkg.
REQ-026 SHALL place valid/tag/data storage in one sub-module icache_line_ram (async read, sync write).

Verification
REQ-027 SHALL cover cold miss: req addr 0x1FC00004 -> four memory reads 0x1FC00000,04,08,0C, then data_ok with word 1, total over 4 handshakes.
REQ-028 SHALL cover back-to-back hits: reqs 0x1FC00000,04,08 on consecutive cycles after refill -> addr_ok every cycle, data_ok each next cycle, no memory traffic.
REQ-029 SHALL cover conflict: 0x00000010 then 0x00000410 (INDEX_W=6) -> second misses, refills, first then misses again.
REQ-030 SHALL cover uncached: req 0xBFC00000 with uncached=1 -> single memory read 0xBFC00000, data passed through, re-request misses again.
REQ-031 SHALL cover reset mid-refill: resetn=0 during MISS_WAIT cnt=2 -> next cycle state IDLE, cache_inst_req=0, line invalid, re-request refills from word 0.
